// File: rtl/perf_event_counters_pkg.sv
// Shared definitions for the performance-counter unit: channel indices,
// default counter width and a ceiling-log2 helper for index sizing.
package perf_pkg;

  localparam int CH_INST   = 0;
  localparam int CH_ICREQ  = 1;
  localparam int CH_ICHIT  = 2;
  localparam int CH_DCREQ  = 3;
  localparam int CH_DCHIT  = 4;
  localparam int CNT_W_DEF = 32;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < value) begin
        r = i + 1;
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/perf_event_counters_if.sv
// Control, event and read-port bundle between the core hierarchy and the
// performance-counter unit.
interface perf_event_counters_if #(
  parameter int NUM_CH = 5,
  parameter int CNT_W  = 32,
  parameter int IDX_W  = 3
);
  logic [NUM_CH-1:0] event_i;
  logic [NUM_CH-1:0] cnt_en_i;
  logic              sat_mode_i;
  logic              halt_i;
  logic              clear_i;
  logic              snap_i;
  logic              rd_req_i;
  logic [IDX_W-1:0]  rd_idx_i;
  logic              rd_valid_o;
  logic [CNT_W-1:0]  rd_data_o;
  logic              rd_ovf_o;
  logic              rd_err_o;
  logic              frozen_o;
  logic [NUM_CH:0]   ovf_o;

  modport master (
    output event_i, cnt_en_i, sat_mode_i, halt_i, clear_i, snap_i, rd_req_i, rd_idx_i,
    input  rd_valid_o, rd_data_o, rd_ovf_o, rd_err_o, frozen_o, ovf_o
  );

  modport slave (
    input  event_i, cnt_en_i, sat_mode_i, halt_i, clear_i, snap_i, rd_req_i, rd_idx_i,
    output rd_valid_o, rd_data_o, rd_ovf_o, rd_err_o, frozen_o, ovf_o
  );
endinterface

// File: rtl/perf_counter_cell.sv
// One counter lane: +1 per enabled cycle, wrap or saturate at all-ones,
// sticky overflow. Next-state is exported so snapshots can include this cycle.
module perf_counter_cell #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clear,
  input  logic             sat_mode,
  output logic [CNT_W-1:0] cnt,
  output logic [CNT_W-1:0] cnt_next,
  output logic             ovf,
  output logic             ovf_next
);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // Next-state: clear dominates, then increment with wrap/saturate at max
  always_comb begin
    cnt_next = cnt;
    ovf_next = ovf;
    if (clear) begin
      cnt_next = {CNT_W{1'b0}};
      ovf_next = 1'b0;
    end else if (inc) begin
      if (cnt == CNT_MAX) begin
        cnt_next = sat_mode ? CNT_MAX : {CNT_W{1'b0}};
        ovf_next = 1'b1;
      end else begin
        cnt_next = cnt + CNT_ONE;
      end
    end else begin
      cnt_next = cnt;
    end
  end

  // Counter and sticky overflow state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= {CNT_W{1'b0}};
      ovf <= 1'b0;
    end else begin
      cnt <= cnt_next;
      ovf <= ovf_next;
    end
  end
endmodule

// File: rtl/perf_event_counters.sv
// Event counters plus a cycle counter, frozen on processor halt, with a
// shadow snapshot bank read through a registered indexed port.
module perf_event_counters
  import perf_pkg::*;
#(
  parameter int NUM_CH = 5,
  parameter int CNT_W  = CNT_W_DEF,
  parameter int IDX_W  = clog2(NUM_CH + 1)
) (
  input logic                  clk,
  input logic                  rst_n,
  perf_event_counters_if.slave bus
);
  logic                 halt_q;
  logic                 frozen;
  logic                 halt_rise;
  logic                 snap_load;
  logic [NUM_CH:0]      inc;
  logic [NUM_CH:0]      ovf_live;
  logic [NUM_CH:0]      ovf_next;
  logic [CNT_W-1:0]     cnt_next [NUM_CH+1];
  logic [CNT_W-1:0]     live_cnt_unused [NUM_CH+1];
  logic [CNT_W-1:0]     shadow_cnt [NUM_CH+1];
  logic [NUM_CH:0]      shadow_ovf;

  assign halt_rise    = bus.halt_i & ~halt_q;
  assign snap_load    = bus.snap_i | halt_rise;
  assign inc[NUM_CH-1:0] = bus.event_i & bus.cnt_en_i & {NUM_CH{~frozen}};
  assign inc[NUM_CH]  = ~frozen;
  assign bus.frozen_o = frozen;
  assign bus.ovf_o    = ovf_live;

  // Lane NUM_CH is the free-running cycle counter
  for (genvar g = 0; g <= NUM_CH; g++) begin : g_cell
    perf_counter_cell #(.CNT_W(CNT_W)) u_cell (
      .clk      (clk),
      .rst_n    (rst_n),
      .inc      (inc[g]),
      .clear    (bus.clear_i),
      .sat_mode (bus.sat_mode_i),
      .cnt      (live_cnt_unused[g]),
      .cnt_next (cnt_next[g]),
      .ovf      (ovf_live[g]),
      .ovf_next (ovf_next[g])
    );
  end

  // Halt edge detect; a halt edge freezes even when clear arrives alongside
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      halt_q <= 1'b0;
      frozen <= 1'b0;
    end else begin
      halt_q <= bus.halt_i;
      if (halt_rise) begin
        frozen <= 1'b1;
      end else if (bus.clear_i) begin
        frozen <= 1'b0;
      end else begin
        frozen <= frozen;
      end
    end
  end

  // Shadow bank captures next-state so the snapshot cycle's events are kept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i <= NUM_CH; i++) begin
        shadow_cnt[i] <= {CNT_W{1'b0}};
      end
      shadow_ovf <= {(NUM_CH+1){1'b0}};
    end else if (snap_load) begin
      for (int i = 0; i <= NUM_CH; i++) begin
        shadow_cnt[i] <= cnt_next[i];
      end
      shadow_ovf <= ovf_next;
    end else begin
      shadow_ovf <= shadow_ovf;
    end
  end

  // Registered read port; data fields hold between requests
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.rd_valid_o <= 1'b0;
      bus.rd_data_o  <= {CNT_W{1'b0}};
      bus.rd_ovf_o   <= 1'b0;
      bus.rd_err_o   <= 1'b0;
    end else begin
      bus.rd_valid_o <= bus.rd_req_i;
      if (bus.rd_req_i) begin
        if (bus.rd_idx_i > IDX_W'(NUM_CH)) begin
          bus.rd_data_o <= {CNT_W{1'b0}};
          bus.rd_ovf_o  <= 1'b0;
          bus.rd_err_o  <= 1'b1;
        end else begin
          bus.rd_data_o <= shadow_cnt[bus.rd_idx_i];
          bus.rd_ovf_o  <= shadow_ovf[bus.rd_idx_i];
          bus.rd_err_o  <= 1'b0;
        end
      end else begin
        bus.rd_data_o <= bus.rd_data_o;
      end
    end
  end
endmodule

// File: tb/tb_perf_event_counters.sv
// Directed bench: a 32-bit instance for general behaviour and a 4-bit
// instance sharing the same stimulus for wrap/saturate corners.
module tb_perf_event_counters;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] ev = 5'd0;
  logic [4:0] en = 5'b11111;
  logic       sat = 1'b0;
  logic       halt = 1'b0;
  logic       clr = 1'b0;
  logic       snp = 1'b0;
  logic       rd_req = 1'b0;
  logic [2:0] rd_idx = 3'd0;
  int         n_pass = 0;
  int         n_total = 0;

  perf_event_counters_if #(.NUM_CH(5), .CNT_W(32), .IDX_W(3)) wb ();
  perf_event_counters_if #(.NUM_CH(5), .CNT_W(4),  .IDX_W(3)) sb ();

  assign wb.event_i = ev;  assign sb.event_i = ev;
  assign wb.cnt_en_i = en; assign sb.cnt_en_i = en;
  assign wb.sat_mode_i = sat; assign sb.sat_mode_i = sat;
  assign wb.halt_i = halt; assign sb.halt_i = halt;
  assign wb.clear_i = clr; assign sb.clear_i = clr;
  assign wb.snap_i = snp;  assign sb.snap_i = snp;
  assign wb.rd_req_i = rd_req; assign sb.rd_req_i = rd_req;
  assign wb.rd_idx_i = rd_idx; assign sb.rd_idx_i = rd_idx;

  perf_event_counters #(.NUM_CH(5), .CNT_W(32), .IDX_W(3)) dut_w (
    .clk(clk), .rst_n(rst_n), .bus(wb.slave));
  perf_event_counters #(.NUM_CH(5), .CNT_W(4), .IDX_W(3)) dut_s (
    .clk(clk), .rst_n(rst_n), .bus(sb.slave));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic apply_reset();
    rst_n = 1'b0; ev = 5'd0; en = 5'b11111; sat = 1'b0; halt = 1'b0;
    clr = 1'b0; snp = 1'b0; rd_req = 1'b0; rd_idx = 3'd0;
    tick(2);
    rst_n = 1'b1;
  endtask

  task automatic snap();
    snp = 1'b1; tick(1); snp = 1'b0;
  endtask

  task automatic issue_read(input logic [2:0] idx);
    rd_req = 1'b1; rd_idx = idx; tick(1); rd_req = 1'b0;
  endtask

  task automatic read_w(input logic [2:0] idx, input logic [31:0] exp_d, input logic exp_o, input string tag);
    issue_read(idx);
    check({tag, ".valid"}, wb.rd_valid_o, 64'd1);
    check({tag, ".data"},  wb.rd_data_o, {32'd0, exp_d});
    check({tag, ".ovf"},   wb.rd_ovf_o, {63'd0, exp_o});
    check({tag, ".err"},   wb.rd_err_o, 64'd0);
  endtask

  initial begin
    // Reset state
    apply_reset();
    check("rst.valid", wb.rd_valid_o, 64'd0);
    check("rst.data", wb.rd_data_o, 64'd0);
    check("rst.frozen", wb.frozen_o, 64'd0);
    check("rst.ovf", wb.ovf_o, 64'd0);

    // Count and read
    ev = 5'b00001; tick(10); ev = 5'd0;
    snap();
    read_w(3'd0, 32'd10, 1'b0, "cnt.ch0");
    tick(1);
    check("cnt.valid_drop", wb.rd_valid_o, 64'd0);
    check("cnt.hold", wb.rd_data_o, 64'd10);
    read_w(3'd1, 32'd0, 1'b0, "cnt.ch1");

    // Enable mask
    apply_reset();
    ev = 5'b11111; en = 5'b10101; tick(4); ev = 5'd0;
    snap();
    read_w(3'd0, 32'd4, 1'b0, "mask.ch0");
    read_w(3'd1, 32'd0, 1'b0, "mask.ch1");
    read_w(3'd2, 32'd4, 1'b0, "mask.ch2");
    read_w(3'd3, 32'd0, 1'b0, "mask.ch3");
    read_w(3'd4, 32'd4, 1'b0, "mask.ch4");

    // Wrap then saturate on the 4-bit instance
    apply_reset();
    sat = 1'b0; ev = 5'b00001; tick(17); ev = 5'd0;
    snap();
    read_w(3'd0, 32'd17, 1'b0, "wrap.wide");
    check("wrap.small.data", sb.rd_data_o, 64'd1);
    check("wrap.small.ovf", sb.rd_ovf_o, 64'd1);
    check("wrap.small.live_ovf", sb.ovf_o[0], 64'd1);
    clr = 1'b1; tick(1); clr = 1'b0;
    check("wrap.clear_ovf", sb.ovf_o[0], 64'd0);
    sat = 1'b1; ev = 5'b00001; tick(20); ev = 5'd0;
    snap();
    read_w(3'd0, 32'd20, 1'b0, "sat.wide");
    check("sat.small.data", sb.rd_data_o, 64'd15);
    check("sat.small.ovf", sb.rd_ovf_o, 64'd1);

    // Halt freeze
    apply_reset();
    ev = 5'b00001; tick(6);
    halt = 1'b1; tick(1);
    check("halt.frozen", wb.frozen_o, 64'd1);
    tick(5); ev = 5'd0;
    check("halt.frozen_held", wb.frozen_o, 64'd1);
    read_w(3'd0, 32'd7, 1'b0, "halt.shadow");
    read_w(3'd5, 32'd7, 1'b0, "halt.cycle");
    snap();
    read_w(3'd0, 32'd7, 1'b0, "halt.live");
    halt = 1'b0; tick(1);
    check("halt.after_drop", wb.frozen_o, 64'd1);
    clr = 1'b1; tick(1); clr = 1'b0;
    check("halt.cleared", wb.frozen_o, 64'd0);

    // Cycle counter and bad index
    apply_reset();
    tick(19);
    snap();
    read_w(3'd5, 32'd20, 1'b0, "cyc.count");
    issue_read(3'd7);
    check("bad7.err", wb.rd_err_o, 64'd1);
    check("bad7.data", wb.rd_data_o, 64'd0);
    check("bad7.valid", wb.rd_valid_o, 64'd1);
    issue_read(3'd6);
    check("bad6.err", wb.rd_err_o, 64'd1);

    // Priority: clear beats event, snapshot loads zeros
    ev = 5'b00001; tick(3);
    clr = 1'b1; snp = 1'b1; tick(1);
    clr = 1'b0; snp = 1'b0; ev = 5'd0;
    read_w(3'd0, 32'd0, 1'b0, "prio.ch0");
    read_w(3'd5, 32'd0, 1'b0, "prio.cycle");
    halt = 1'b1; clr = 1'b1; tick(1);
    halt = 1'b0; clr = 1'b0;
    check("prio.clr_halt_frozen", wb.frozen_o, 64'd1);
    clr = 1'b1; tick(1); clr = 1'b0;

    // Asynchronous reset mid-operation
    ev = 5'b00001; snp = 1'b1; tick(1); snp = 1'b0;
    halt = 1'b1; tick(1); halt = 1'b0;
    read_w(3'd0, 32'd2, 1'b0, "mid.pre");
    check("mid.pre_frozen", wb.frozen_o, 64'd1);
    rst_n = 1'b0;
    #2;
    check("mid.valid", wb.rd_valid_o, 64'd0);
    check("mid.data", wb.rd_data_o, 64'd0);
    check("mid.frozen", wb.frozen_o, 64'd0);
    check("mid.ovf", wb.ovf_o, 64'd0);
    check("mid.small_frozen", sb.frozen_o, 64'd0);
    ev = 5'd0;
    tick(2);
    rst_n = 1'b1;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/perf_event_counters.md
Name: perf_event_counters

Overview:
- Synthesizable, parametrised hardware performance-counter unit. It is the on-chip successor to the bench-side instruction and cache-hit/request counting.
- Counts NUM_CH independent single-bit event channels plus a free-running cycle counter.
- Freezes and snapshots all counts when the processor halts.
- Exposes a shadow snapshot bank through an indexed read port with one-cycle latency.
- Sits beside proc inside proc_hier; event inputs come from the commit and cache-interface signals.

Parameters:
- NUM_CH, 5: number of event channels (inst, icache req, icache hit, dcache req, dcache hit).
- CNT_W, 32: width of every counter, including the cycle counter.
- IDX_W, 3: read-index width; must satisfy 2**IDX_W > NUM_CH.

Ports:
- clk, input, 1: single clock; all state updates on the rising edge.
- rst_n, input, 1: asynchronous, active-low reset.
- event_i, input, NUM_CH: per-channel event strobes, one count per cycle high.
- cnt_en_i, input, NUM_CH: per-channel enable mask.
- sat_mode_i, input, 1: 1 = saturate at max, 0 = wrap to 0.
- halt_i, input, 1: processor halt indication, level.
- clear_i, input, 1: synchronous clear of live counters, overflow flags and frozen state.
- snap_i, input, 1: software snapshot request.
- rd_req_i, input, 1: read request.
- rd_idx_i, input, IDX_W: read index; 0..NUM_CH-1 selects a channel, NUM_CH selects the cycle counter.
- rd_valid_o, output, 1: read data valid, one cycle after rd_req_i.
- rd_data_o, output, CNT_W: shadow value at the requested index.
- rd_ovf_o, output, 1: shadow overflow flag at the requested index.
- rd_err_o, output, 1: index out of range (> NUM_CH).
- frozen_o, output, 1: counting is frozen.
- ovf_o, output, NUM_CH+1: live sticky overflow flags; bit NUM_CH belongs to the cycle counter.

Behaviour:
- Reset (rst_n low, asynchronous): all of the following clear to 0: live counters, shadow counters, shadow and live ovf, frozen_o, rd_valid_o, rd_data_o, rd_ovf_o, rd_err_o, and the internal halt_q.
- Increment: channel i increments when event_i[i] & cnt_en_i[i] & ~frozen. The cycle counter increments every cycle while ~frozen. Increment is exactly +1 per cycle.
- Overflow when a counter equals 2**CNT_W-1 and increments:
  - sat_mode_i=1: counter holds at max and ovf sets.
  - sat_mode_i=0: counter goes to 0 and ovf sets.
  - ovf is sticky until clear_i or reset. sat_mode_i is sampled every cycle.
- Freeze:
  - Rising edge of halt_i (halt_i & ~halt_q) sets frozen. Frozen stays set while halt_i is held and after it drops, until clear_i.
  - The halt cycle's own events are counted, i.e. the update is computed before freeze takes effect.
- Snapshot:
  - On snap_i or a halt_i rising edge, the shadow bank loads the next-state value of every live counter and ovf flag, including that cycle's increment.
  - Snapshot while frozen copies the frozen values.
- Clear: live counters and ovf go to 0 and frozen clears. The shadow bank is untouched.
- Priority within one cycle:
  - clear_i beats increment.
  - clear_i with halt rising edge: counters go to 0 and frozen sets.
  - clear_i with snap_i: shadow loads zeros.
- Read:
  - Registered, latency 1. rd_valid_o is high exactly the cycle after rd_req_i, otherwise 0.
  - idx > NUM_CH: rd_data_o=0, rd_ovf_o=0, rd_err_o=1.
  - rd_data_o, rd_ovf_o and rd_err_o hold their last values when rd_valid_o=0.
  - A read on the same cycle as a snapshot returns the pre-snapshot shadow value.
  - Back-to-back reads are allowed every cycle.
- Reset mid-operation: all state is lost immediately and no output glitch is held past reset deassertion.

Decomposition:
- Shared package perf_pkg holds:
  - Channel index constants CH_INST=0, CH_ICREQ=1, CH_ICHIT=2, CH_DCREQ=3, CH_DCHIT=4.
  - Default CNT_W.
  - A clog2 function for deriving IDX_W.
- One sub-module, perf_counter_cell, replicated NUM_CH+1 times:
  - Inputs: inc, clear, sat_mode.
  - Outputs: cnt, cnt_next, ovf, ovf_next.
  - Contains CNT_W counter, saturate/wrap logic and sticky ovf.

Test Plan:
- Count and read: reset, then 10 cycles of event_i=5'b00001 with cnt_en_i=all-1, then snap_i, then read idx 0 → rd_valid next cycle, rd_data=10. Read idx 1 → 0.
- Enable mask: event_i=all-1 for 4 cycles with cnt_en_i=5'b10101, then snap, then read channels 0..4 → 4, 0, 4, 0, 4.
- Wrap vs saturate (CNT_W=4):
  - sat_mode=0: 17 events, then snap → ch0 reads 1, rd_ovf=1.
  - clear, then sat_mode=1: 20 events, then snap → ch0 reads 15, rd_ovf=1.
- Halt freeze: 7 events with halt_i rising on the 7th, then 5 more events → shadow ch0=7, frozen_o=1, live count unchanged. clear_i → frozen_o=0.
- Cycle counter and bad index:
  - 20 cycles after reset, then snap → read idx NUM_CH=5 returns 20 (±0; define reference at snap edge).
  - Read idx 7 → rd_err_o=1, rd_data_o=0.
- Priority and reset: clear_i with event and snap in one cycle → shadow ch0=0. Assert rst_n low mid-count → all outputs 0 asynchronously, before the next clk edge.
